// File: rtl/m_pcpi_adapter.sv
// m_pcpi_adapter
//   Bridges the PicoRV32 PCPI port to a multi-cycle RV32M execution unit.
//   Decodes RV32M instructions (all eight funct3 ops), latches the operands,
//   fires a one-cycle start to the M unit, waits for its completion pulse and
//   returns the result to the core with the wait/ready/wr handshake.
//   Non-M instructions are ignored so other co-processors can share the bus.
//
// Parameters
//   TIMEOUT_CYCLES  WAIT-cycle limit before a forced abort response (>= 2).
//                   Only meaningful when M_PCPI_TIMEOUT_EN is defined.
//
// Optional feature
//   M_PCPI_TIMEOUT_EN  builds the WAIT timeout counter and the sticky
//                      timeout_err flag; undefined = wait forever, flag tied 0.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   pcpi_valid/insn/rs1/rs2            request from the core
//   pcpi_wr/rd/wait/ready              response to the core (wr/rd zero unless ready)
//   m_valid/instruction/rs1/rs2        start pulse and latched request to M unit
//   m_wr/rd/busy/ready                 status and result from M unit
//   timeout_err                        sticky timeout flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; accepts a matching instruction
// ISSUE | m_valid pulse to the M unit
// WAIT  | stalling the core until m_ready (or abort / timeout)
// RESP  | pcpi_ready pulse with the captured result
// DRAIN | wait for pcpi_valid low (and unit idle) before re-arming

module m_pcpi_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("m_pcpi_adapter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] m_instruction_q, m_instruction_d;
  logic [31:0] m_rs1_q, m_rs1_d;
  logic [31:0] m_rs2_q, m_rs2_d;
  logic        m_valid_q, m_valid_d;
  logic        pcpi_wait_q, pcpi_wait_d;
  logic        pcpi_ready_q, pcpi_ready_d;
  logic        pcpi_wr_q, pcpi_wr_d;
  logic [31:0] pcpi_rd_q, pcpi_rd_d;
  logic        insn_match;

`ifdef M_PCPI_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
  // Set when DRAIN follows a timeout: the unit may be hung, so m_busy is
  // not allowed to hold the adapter in DRAIN.
  logic          hung_q, hung_d;
`endif

  assign insn_match = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);

  always_comb begin
    state_d         = state_q;
    m_instruction_d = m_instruction_q;
    m_rs1_d         = m_rs1_q;
    m_rs2_d         = m_rs2_q;
    pcpi_ready_d    = 1'b0;
    pcpi_wr_d       = 1'b0;
    pcpi_rd_d       = 32'd0;
`ifdef M_PCPI_TIMEOUT_EN
    cnt_d           = cnt_q;
    timeout_err_d   = timeout_err_q;
    hung_d          = hung_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pcpi_valid && insn_match) begin
          m_instruction_d = pcpi_insn;
          m_rs1_d         = pcpi_rs1;
          m_rs2_d         = pcpi_rs2;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef M_PCPI_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // m_ready has priority over a simultaneous core abort.
        if (m_ready) begin
          pcpi_ready_d = 1'b1;
          pcpi_wr_d    = m_wr;
          pcpi_rd_d    = m_rd;
          state_d      = S_RESP;
        end else if (!pcpi_valid) begin
          state_d = S_DRAIN;
        end
`ifdef M_PCPI_TIMEOUT_EN
        // cnt_q is the number of WAIT cycles already completed.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          pcpi_ready_d  = 1'b1;
          timeout_err_d = 1'b1;
          hung_d        = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef M_PCPI_TIMEOUT_EN
        if (!pcpi_valid && (!m_busy || hung_q)) begin
          hung_d  = 1'b0;
          state_d = S_IDLE;
        end
`else
        if (!pcpi_valid && !m_busy) begin
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    m_valid_d   = (state_d == S_ISSUE);
    pcpi_wait_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      m_instruction_q <= '0;
      m_rs1_q         <= '0;
      m_rs2_q         <= '0;
      m_valid_q       <= 1'b0;
      pcpi_wait_q     <= 1'b0;
      pcpi_ready_q    <= 1'b0;
      pcpi_wr_q       <= 1'b0;
      pcpi_rd_q       <= '0;
`ifdef M_PCPI_TIMEOUT_EN
      cnt_q           <= '0;
      timeout_err_q   <= 1'b0;
      hung_q          <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      m_instruction_q <= m_instruction_d;
      m_rs1_q         <= m_rs1_d;
      m_rs2_q         <= m_rs2_d;
      m_valid_q       <= m_valid_d;
      pcpi_wait_q     <= pcpi_wait_d;
      pcpi_ready_q    <= pcpi_ready_d;
      pcpi_wr_q       <= pcpi_wr_d;
      pcpi_rd_q       <= pcpi_rd_d;
`ifdef M_PCPI_TIMEOUT_EN
      cnt_q           <= cnt_d;
      timeout_err_q   <= timeout_err_d;
      hung_q          <= hung_d;
`endif
    end
  end

  assign m_valid       = m_valid_q;
  assign m_instruction = m_instruction_q;
  assign m_rs1         = m_rs1_q;
  assign m_rs2         = m_rs2_q;
  assign pcpi_wait     = pcpi_wait_q;
  assign pcpi_ready    = pcpi_ready_q;
  assign pcpi_wr       = pcpi_wr_q;
  assign pcpi_rd       = pcpi_rd_q;
`ifdef M_PCPI_TIMEOUT_EN
  assign timeout_err   = timeout_err_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_m_pcpi_adapter.sv
module tb_m_pcpi_adapter;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        m_valid;
  logic [31:0] m_instruction;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_wr;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_ready;
  logic        timeout_err;

  int checks;
  int failures;
  int mv_cnt;
  int pr_cnt;

  m_pcpi_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .pcpi_valid    (pcpi_valid),
    .pcpi_insn     (pcpi_insn),
    .pcpi_rs1      (pcpi_rs1),
    .pcpi_rs2      (pcpi_rs2),
    .pcpi_wr       (pcpi_wr),
    .pcpi_rd       (pcpi_rd),
    .pcpi_wait     (pcpi_wait),
    .pcpi_ready    (pcpi_ready),
    .m_valid       (m_valid),
    .m_instruction (m_instruction),
    .m_rs1         (m_rs1),
    .m_rs2         (m_rs2),
    .m_wr          (m_wr),
    .m_rd          (m_rd),
    .m_busy        (m_busy),
    .m_ready       (m_ready),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters for the "exactly one pulse" rules
  initial begin
    mv_cnt = 0;
    pr_cnt = 0;
  end
  always @(negedge clk) begin
    if (m_valid) mv_cnt = mv_cnt + 1;
    if (pcpi_ready) pr_cnt = pr_cnt + 1;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the RV32M unit computes for a given funct3.
  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = int'(a);
    ib = int'(b);
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_m(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
  endfunction

  function automatic logic [31:0] rand_m_insn(input logic [2:0] f3);
    return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
  endfunction

  // One full M transaction. lat = cycles from the m_valid cycle to m_ready.
  task automatic do_txn(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input bit drop_at_ready, input bit early_ready);
    logic [31:0] exp;
    int mv0, pr0;
    exp = rv32m(insn[14:12], a, b);
    mv0 = mv_cnt;
    pr0 = pr_cnt;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    tick();
    chk1("accept_m_valid", m_valid, 1'b1);
    chk1("accept_wait", pcpi_wait, 1'b1);
    chk32("m_instruction", m_instruction, insn);
    chk32("m_rs1", m_rs1, a);
    chk32("m_rs2", m_rs2, b);
    m_busy = 1'b1;
    if (early_ready) begin
      m_ready = 1'b1;
      m_rd    = ~exp;
      m_wr    = 1'b1;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      m_ready = 1'b0;
      chk1("wait_no_m_valid", m_valid, 1'b0);
      chk1("wait_pcpi_wait", pcpi_wait, 1'b1);
      chk1("wait_no_ready", pcpi_ready, 1'b0);
      chk32("wait_rd_zero", pcpi_rd, 32'd0);
    end
    m_ready = 1'b1;
    m_rd    = exp;
    m_wr    = 1'b1;
    m_busy  = 1'b0;
    if (drop_at_ready) pcpi_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    m_rd    = $urandom;
    m_wr    = 1'b0;
    chk1("resp_ready", pcpi_ready, 1'b1);
    chk32("resp_rd", pcpi_rd, exp);
    chk1("resp_wr", pcpi_wr, 1'b1);
    chk1("resp_wait", pcpi_wait, 1'b1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk1("hold_no_ready", pcpi_ready, 1'b0);
      chk1("hold_no_wait", pcpi_wait, 1'b0);
      chk32("hold_rd_zero", pcpi_rd, 32'd0);
    end
    pcpi_valid = 1'b0;
    tick();
    tick();
    chk1("post_no_wait", pcpi_wait, 1'b0);
    chk32("one_m_valid", 32'(mv_cnt - mv0), 32'd1);
    chk32("one_pcpi_ready", 32'(pr_cnt - pr0), 32'd1);
    chk32("m_rs1_held", m_rs1, a);
    chk1("no_timeout_err", timeout_err, 1'b0);
  endtask

  initial begin
    logic [31:0] insn, a;
    int mv0, pr0;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    m_wr       = 1'b0;
    m_rd       = '0;
    m_busy     = 1'b0;
    m_ready    = 1'b0;
    tick();
    tick();
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_wait", pcpi_wait, 1'b0);
    chk1("rst_ready", pcpi_ready, 1'b0);
    chk1("rst_wr", pcpi_wr, 1'b0);
    chk32("rst_rd", pcpi_rd, 32'd0);
    chk32("rst_m_insn", m_instruction, 32'd0);
    chk32("rst_m_rs1", m_rs1, 32'd0);
    chk32("rst_m_rs2", m_rs2, 32'd0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    tick();

    // directed MUL, 4-cycle unit
    do_txn(32'h02B5_0533, 32'd7, 32'd6, 4, 0, 1'b0, 1'b0);

    // non-M instructions, valid held 10 cycles
    mv0 = mv_cnt;
    pr0 = pr_cnt;
    for (int k = 0; k < 4; k++) begin
      insn = (k == 0) ? 32'h00B5_0533 : $urandom;
      if (is_m(insn)) insn[25] = 1'b0;
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk1("nonm_m_valid", m_valid, 1'b0);
        chk1("nonm_wait", pcpi_wait, 1'b0);
        chk1("nonm_ready", pcpi_ready, 1'b0);
      end
      pcpi_valid = 1'b0;
      tick();
    end
    chk32("nonm_pulses", 32'(mv_cnt - mv0 + pr_cnt - pr0), 32'd0);

    // held pcpi_valid after ready
    do_txn(32'h02B5_0533, $urandom, $urandom, 1, 3, 1'b0, 1'b0);

    // randomized transactions across all eight ops and corner timings
    for (int k = 0; k < 24; k++) begin
      do_txn(rand_m_insn(3'($urandom)), $urandom, $urandom,
             int'($urandom_range(6, 2)), int'($urandom_range(3, 0)),
             1'($urandom), 1'($urandom));
    end
    // simultaneous m_ready and pcpi_valid drop, minimum latency
    do_txn(rand_m_insn(3'd0), $urandom, $urandom, 1, 0, 1'b1, 1'b0);

    // core abort
    pr0 = pr_cnt;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h02B5_0533;
    pcpi_rs1   = 32'd3;
    pcpi_rs2   = 32'd5;
    tick();
    chk1("abort_m_valid", m_valid, 1'b1);
    m_busy = 1'b1;
    tick();
    tick();
    pcpi_valid = 1'b0;
    tick();
    chk1("abort_drain_wait", pcpi_wait, 1'b0);
    tick();
    tick();
    m_ready = 1'b1;
    m_rd    = 32'd15;
    m_wr    = 1'b1;
    m_busy  = 1'b0;
    tick();
    m_ready = 1'b0;
    m_wr    = 1'b0;
    chk1("abort_no_ready", pcpi_ready, 1'b0);
    tick();
    tick();
    chk32("abort_no_ready_cnt", 32'(pr_cnt - pr0), 32'd0);
    do_txn(32'h02B5_0533, 32'd9, 32'd9, 3, 0, 1'b0, 1'b0);

    // reset in WAIT
    pr0 = pr_cnt;
    a = $urandom | 32'd1;
    pcpi_valid = 1'b1;
    pcpi_insn  = rand_m_insn(3'd3);
    pcpi_rs1   = a;
    pcpi_rs2   = ~a;
    m_busy     = 1'b1;
    tick();
    tick();
    chk1("prereset_wait", pcpi_wait, 1'b1);
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    tick();
    reset  = 1'b0;
    m_busy = 1'b0;
    chk1("midrst_m_valid", m_valid, 1'b0);
    chk1("midrst_wait", pcpi_wait, 1'b0);
    chk1("midrst_ready", pcpi_ready, 1'b0);
    chk32("midrst_m_insn", m_instruction, 32'd0);
    chk32("midrst_m_rs1", m_rs1, 32'd0);
    chk32("midrst_m_rs2", m_rs2, 32'd0);
    tick();
    m_ready = 1'b1;
    m_rd    = 32'hDEAD_BEEF;
    m_wr    = 1'b1;
    tick();
    m_ready = 1'b0;
    m_wr    = 1'b0;
    tick();
    tick();
    chk32("stray_ready_cnt", 32'(pr_cnt - pr0), 32'd0);
    chk1("stray_no_wait", pcpi_wait, 1'b0);

`ifdef M_PCPI_TIMEOUT_EN
    // hung unit: forced response after TO WAIT cycles
    m_busy     = 1'b1;
    m_rd       = 32'h1234_5678;
    pcpi_valid = 1'b1;
    pcpi_insn  = rand_m_insn(3'd1);
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    tick();
    chk1("to_m_valid", m_valid, 1'b1);
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      chk1("to_no_ready", pcpi_ready, 1'b0);
      chk1("to_wait", pcpi_wait, 1'b1);
    end
    tick();
    chk1("to_ready", pcpi_ready, 1'b1);
    chk32("to_rd", pcpi_rd, 32'd0);
    chk1("to_wr", pcpi_wr, 1'b0);
    chk1("to_err", timeout_err, 1'b1);
    pcpi_valid = 1'b0;
    tick();
    tick();
    // m_busy still high: DRAIN must not hold, a new accept must start
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h02B5_0533;
    pcpi_rs1   = 32'd2;
    pcpi_rs2   = 32'd21;
    tick();
    chk1("to_reaccept", m_valid, 1'b1);
    m_ready = 1'b1;
    m_rd    = 32'd42;
    m_wr    = 1'b1;
    tick();
    tick();
    m_ready = 1'b0;
    chk1("to_next_ready", pcpi_ready, 1'b1);
    chk32("to_next_rd", pcpi_rd, 32'd42);
    chk1("to_err_sticky", timeout_err, 1'b1);
    pcpi_valid = 1'b0;
    m_busy     = 1'b0;
    tick();
    tick();
    chk1("to_err_sticky2", timeout_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("to_err_cleared", timeout_err, 1'b0);
`else
    // without the timeout the adapter waits indefinitely
    m_busy     = 1'b1;
    pcpi_valid = 1'b1;
    pcpi_insn  = rand_m_insn(3'd5);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    tick();
    pr0 = pr_cnt;
    repeat (80) tick();
    chk32("no_to_ready_cnt", 32'(pr_cnt - pr0), 32'd0);
    chk1("no_to_wait", pcpi_wait, 1'b1);
    chk1("no_to_err", timeout_err, 1'b0);
    m_ready = 1'b1;
    m_rd    = rv32m(3'd5, 32'd100, 32'd7);
    m_wr    = 1'b1;
    m_busy  = 1'b0;
    tick();
    m_ready = 1'b0;
    chk1("no_to_ready", pcpi_ready, 1'b1);
    chk32("no_to_rd", pcpi_rd, 32'd14);
    pcpi_valid = 1'b0;
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_pcpi_adapter.md
# m_pcpi_adapter

Front-end stage between the PicoRV32 PCPI port and the multi-cycle M-extension unit. Decodes RV32M instructions, latches the operands, issues a one-cycle start to the M unit, waits for its completion, and returns the result to the core with the PCPI wait/ready/wr handshake. Non-M instructions are ignored, so other co-processors can share the PCPI bus.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a forced abort response. Used only with the timeout feature; must be ≥ 2.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pcpi_valid  in  1  core presents an instruction
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  write rd; valid only with pcpi_ready
- pcpi_rd  out  32  result; valid only with pcpi_ready
- pcpi_wait  out  1  stall request to the core
- pcpi_ready  out  1  one-cycle completion pulse
- m_valid  out  1  one-cycle start pulse to the M unit
- m_instruction  out  32  latched instruction
- m_rs1  out  32  latched rs1
- m_rs2  out  32  latched rs2
- m_wr  in  1  M unit write-enable, sampled with m_ready
- m_rd  in  32  M unit result, sampled with m_ready
- m_busy  in  1  M unit busy
- m_ready  in  1  M unit completion pulse
- timeout_err  out  1  sticky timeout flag

## Operation
- Match condition: pcpi_insn[6:0] == 7'b0110011 and pcpi_insn[31:25] == 7'b0000001. funct3 is not checked, so all 8 ops match.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If pcpi_valid and the instruction matches: latch insn, rs1 and rs2 into the m_* registers, then go to ISSUE.
  - Otherwise stay in IDLE with all outputs inactive.
- ISSUE:
  - m_valid = 1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - If m_ready: capture m_rd and m_wr into the response registers, then go to RESP.
  - Else if pcpi_valid == 0 (core abort): go to DRAIN and mark the result as discarded.
- RESP:
  - pcpi_ready = 1 for one cycle, with pcpi_wr and pcpi_rd taken from the captured values.
  - Go to DRAIN.
- DRAIN:
  - Return to IDLE when pcpi_valid == 0 and m_busy == 0.
  - A discarded m_ready arriving in DRAIN is consumed silently.
  - This prevents re-accepting the same instruction while the core is still holding pcpi_valid.
- pcpi_wait = 1 in ISSUE, WAIT and RESP; 0 in IDLE and DRAIN.
- m_instruction, m_rs1 and m_rs2 hold their latched values until the next accept.
- pcpi_rd and pcpi_wr read 0 whenever pcpi_ready == 0.
- No arithmetic in this block. Data passes through bit-exact at 32 bits.

## Timing
- Reset (synchronous, active-high, on the clk edge where reset == 1):
  - State returns to IDLE.
  - All outputs go to 0: pcpi_*, m_valid, m_instruction, m_rs1, m_rs2, timeout_err.
  - The counter clears.
  - Reset mid-operation abandons the transaction; any later m_ready is ignored until a new accept.
- Accept to m_valid: m_valid is high in cycle T+1, where T is the cycle in which pcpi_valid is sampled high with a match. pcpi_wait is high from T+1 onward.
- m_ready at cycle N (N ≥ T+2) gives pcpi_ready at N+1.
- Minimum total latency, pcpi_valid to pcpi_ready, is 3 cycles.
- Simultaneous m_ready and pcpi_valid drop in WAIT: m_ready wins, go to RESP; the response is still issued.
- m_ready is ignored in IDLE and ISSUE.
- The earliest re-accept is the cycle after DRAIN exits. Back-to-back instructions therefore need at least one IDLE cycle between them.

## Configuration
- M_PCPI_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the counter reaches TIMEOUT_CYCLES without m_ready: go to RESP with pcpi_wr = 0 and pcpi_rd = 0, and set timeout_err = 1.
  - timeout_err is sticky until reset.
  - The DRAIN exit condition then ignores m_busy (a hung unit must not deadlock the core).
- M_PCPI_TIMEOUT_EN undefined:
  - No counter is built and timeout_err is tied to 0.
  - WAIT waits indefinitely.

## Test plan
- **MUL, 4-cycle unit:** pcpi_insn = 0x02B50533 (mul a0,a0,a1), rs1 = 7, rs2 = 6; the M model asserts m_ready 4 cycles after m_valid with m_rd = 42, m_wr = 1. Required: one m_valid pulse carrying m_rs1 = 7 and m_rs2 = 6; pcpi_ready exactly 1 cycle after m_ready with pcpi_rd = 42 and pcpi_wr = 1; pcpi_wait high throughout.
- **Non-M instruction:** pcpi_insn = 0x00B50533 (add) with pcpi_valid held for 10 cycles. Required: m_valid, pcpi_wait and pcpi_ready all stay 0.
- **Core abort:** pcpi_valid dropped 2 cycles after m_valid; m_ready arrives 3 cycles later. Required: no pcpi_ready; the FSM reaches IDLE after m_busy falls; the next MUL completes normally.
- **Held pcpi_valid:** pcpi_valid held for 3 cycles after pcpi_ready. Required: exactly one m_valid pulse and one pcpi_ready pulse in total.
- **Reset mid-WAIT:** reset = 1 for 1 cycle while in WAIT. Required: all outputs 0 on the next cycle; a later stray m_ready produces no pcpi_ready.
- **Timeout (M_PCPI_TIMEOUT_EN, TIMEOUT_CYCLES = 8):** the M unit never asserts m_ready. Required: pcpi_ready at the 8th WAIT cycle + 1 with pcpi_wr = 0 and pcpi_rd = 0; timeout_err = 1 and stays high until reset.
